structure_tape_reader: RTL and testbench

- Walks a completed structure tape in block RAM, one 64-bit JsonTapeElement at a time, and decodes each word back into an element type and payload.
- It is the decode-side counterpart of the structure-tape encoder, which builds each word as an 8-bit type char plus a 56-bit payload.
- Feeds downstream consumers (serializer, checker, AXI readback) through a valid/ready stream.
- Also tracks nesting depth and flags malformed tapes.

---
 rtl/structure_tape_reader_pkg.sv | 99 +++++++++
 rtl/structure_tape_reader_tape_word_decoder.sv | 27 ++
 rtl/structure_tape_reader.sv | 196 +++++++++++++++++++
 tb/tb_structure_tape_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/structure_tape_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : structure_tape_reader_pkg
// Description : Shared tape types and helpers for the structure-tape reader:
//               element types, tape index, tape-char mapping in both
//               directions, reader error codes and reader states.
// Revision    : 1.0 - initial release
// ============================================================================
package structure_tape_reader_pkg;

    localparam int TAPE_INDEX_W = 16;

    typedef logic [TAPE_INDEX_W-1:0] tape_index_t;
    typedef logic [63:0]             json_tape_element_t;

    typedef enum logic [3:0] {
        ELEM_STR         = 4'd0,
        ELEM_OBJ_OPEN    = 4'd1,
        ELEM_OBJ_CLOSE   = 4'd2,
        ELEM_ARRAY_OPEN  = 4'd3,
        ELEM_ARRAY_CLOSE = 4'd4,
        ELEM_TRUE        = 4'd5,
        ELEM_FALSE       = 4'd6,
        ELEM_NULL        = 4'd7,
        ELEM_UINT        = 4'd8,
        ELEM_SINT        = 4'd9,
        ELEM_DOUBLE      = 4'd10
    } element_type_t;

    typedef enum logic [1:0] {
        TR_ERR_NONE       = 2'd0,
        TR_ERR_BAD_PREFIX = 2'd1,
        TR_ERR_DEPTH      = 2'd2,
        TR_ERR_TRUNCATED  = 2'd3
    } tape_reader_err_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT      = 3'd2,
        S_NUM_FETCH = 3'd3,
        S_NUM_WAIT  = 3'd4,
        S_PRESENT   = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } tape_reader_state_t;

    // Encoder-side mapping: element type to the 8-bit tape char.
    function automatic logic [7:0] element_type_to_tape_char(input element_type_t t);
        case (t)
            ELEM_STR:         return 8'h22;
            ELEM_OBJ_OPEN:    return 8'h7B;
            ELEM_OBJ_CLOSE:   return 8'h7D;
            ELEM_ARRAY_OPEN:  return 8'h5B;
            ELEM_ARRAY_CLOSE: return 8'h5D;
            ELEM_TRUE:        return 8'h74;
            ELEM_FALSE:       return 8'h66;
            ELEM_NULL:        return 8'h6E;
            ELEM_UINT:        return 8'h75;
            ELEM_SINT:        return 8'h6C;
            ELEM_DOUBLE:      return 8'h64;
            default:          return 8'h00;
        endcase
    endfunction

    // Decoder-side mapping, inverse of the above; unknown chars map to
    // ELEM_STR and must be screened with is_known_tape_char().
    function automatic element_type_t tape_char_to_element_type(input logic [7:0] c);
        case (c)
            8'h22:   return ELEM_STR;
            8'h7B:   return ELEM_OBJ_OPEN;
            8'h7D:   return ELEM_OBJ_CLOSE;
            8'h5B:   return ELEM_ARRAY_OPEN;
            8'h5D:   return ELEM_ARRAY_CLOSE;
            8'h74:   return ELEM_TRUE;
            8'h66:   return ELEM_FALSE;
            8'h6E:   return ELEM_NULL;
            8'h75:   return ELEM_UINT;
            8'h6C:   return ELEM_SINT;
            8'h64:   return ELEM_DOUBLE;
            default: return ELEM_STR;
        endcase
    endfunction

    function automatic logic is_known_tape_char(input logic [7:0] c);
        case (c)
            8'h22, 8'h7B, 8'h7D, 8'h5B, 8'h5D, 8'h74,
            8'h66, 8'h6E, 8'h75, 8'h6C, 8'h64: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Numbers occupy two tape words: the tagged word plus a raw value word.
    function automatic logic is_number_type(input element_type_t t);
        return (t == ELEM_UINT) || (t == ELEM_SINT) || (t == ELEM_DOUBLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/structure_tape_reader_tape_word_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tape_word_decoder
// Description : Combinational split of one 64-bit tape word into element
//               type, 56-bit payload, bad-prefix flag and number flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_word_decoder
    import structure_tape_reader_pkg::*;
(
    input  logic [63:0]   word,
    output element_type_t elem_type,
    output logic [55:0]   payload,
    output logic          bad_prefix,
    output logic          is_number
);

    logic [7:0] w_prefix;

    assign w_prefix   = word[63:56];
    assign payload    = word[55:0];
    assign elem_type  = tape_char_to_element_type(w_prefix);
    assign bad_prefix = ~is_known_tape_char(w_prefix);
    assign is_number  = is_known_tape_char(w_prefix) & is_number_type(elem_type);

endmodule
`default_nettype wire

// File: rtl/structure_tape_reader.sv
`default_nettype none
// ============================================================================
// Module      : structure_tape_reader
// Description : Walks a finished structure tape in block RAM, decodes each
//               element (fetching the value word for numbers), presents it on
//               a valid/ready stream, tracks nesting depth and reports
//               malformed tapes through a sticky error code.
// Revision    : 1.0 - initial release
// ============================================================================
module structure_tape_reader
    import structure_tape_reader_pkg::*;
#(
    parameter int MAX_DEPTH = 32,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  tape_index_t         tape_len,
    output logic                mem_rd_en,
    output tape_index_t         mem_addr,
    input  logic [63:0]         mem_rd_data,
    output logic                elem_valid,
    input  logic                elem_ready,
    output element_type_t       elem_type,
    output logic [55:0]         elem_payload,
    output logic [63:0]         elem_value,
    output tape_index_t         elem_index,
    output logic [DEPTH_W-1:0]  elem_depth,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err_code
);

    tape_reader_state_t  r_state;
    tape_index_t         r_len;
    tape_index_t         r_index;
    logic [DEPTH_W-1:0]  r_depth;

    element_type_t       w_dec_type;
    logic [55:0]         w_dec_payload;
    logic                w_dec_bad;
    logic                w_dec_num;

    logic                w_is_open;
    logic                w_is_close;
    logic                w_depth_err;
    logic [DEPTH_W-1:0]  w_depth_next;
    tape_index_t         w_index_next;
    logic [TAPE_INDEX_W:0] w_idx_p1;

    tape_word_decoder u_decoder (
        .word       (mem_rd_data),
        .elem_type  (w_dec_type),
        .payload    (w_dec_payload),
        .bad_prefix (w_dec_bad),
        .is_number  (w_dec_num)
    );

    assign w_is_open  = (elem_type == ELEM_OBJ_OPEN)  || (elem_type == ELEM_ARRAY_OPEN);
    assign w_is_close = (elem_type == ELEM_OBJ_CLOSE) || (elem_type == ELEM_ARRAY_CLOSE);

    // One extra bit so the value-word bound check cannot wrap.
    assign w_idx_p1 = {1'b0, r_index} + (TAPE_INDEX_W+1)'(1);

    assign w_index_next = r_index + (is_number_type(elem_type) ? tape_index_t'(2)
                                                               : tape_index_t'(1));

    // Depth update and over/underflow detection for the presented element.
    always_comb begin
        w_depth_next = r_depth;
        w_depth_err  = 1'b0;
        if (w_is_open) begin
            if (r_depth == DEPTH_W'(MAX_DEPTH)) w_depth_err  = 1'b1;
            else                                w_depth_next = r_depth + DEPTH_W'(1);
        end else if (w_is_close) begin
            if (r_depth == '0) w_depth_err  = 1'b1;
            else               w_depth_next = r_depth - DEPTH_W'(1);
        end
    end

    // Walk state machine; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_index      <= '0;
            r_depth      <= '0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            elem_valid   <= 1'b0;
            elem_type    <= ELEM_STR;
            elem_payload <= '0;
            elem_value   <= '0;
            elem_index   <= '0;
            elem_depth   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_code     <= TR_ERR_NONE;
        end else begin
            // Single-cycle strobes fall back unless re-armed below.
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        r_len      <= tape_len;
                        r_index    <= '0;
                        r_depth    <= '0;
                        err_code   <= TR_ERR_NONE;
                        elem_valid <= 1'b0;
                        if (tape_len == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state   <= S_FETCH;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= '0;
                            busy      <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    elem_type    <= w_dec_type;
                    elem_payload <= w_dec_payload;
                    elem_value   <= '0;
                    elem_index   <= r_index;
                    elem_depth   <= r_depth;
                    if (w_dec_bad) begin
                        err_code <= TR_ERR_BAD_PREFIX;
                        busy     <= 1'b0;
                        r_state  <= S_ERROR;
                    end else if (w_dec_num) begin
                        if (w_idx_p1 >= {1'b0, r_len}) begin
                            err_code <= TR_ERR_TRUNCATED;
                            busy     <= 1'b0;
                            r_state  <= S_ERROR;
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= w_idx_p1[TAPE_INDEX_W-1:0];
                            r_state   <= S_NUM_FETCH;
                        end
                    end else begin
                        elem_valid <= 1'b1;
                        r_state    <= S_PRESENT;
                    end
                end
                S_NUM_FETCH: begin
                    r_state <= S_NUM_WAIT;
                end
                S_NUM_WAIT: begin
                    elem_value <= mem_rd_data;
                    elem_valid <= 1'b1;
                    r_state    <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (elem_ready) begin
                        elem_valid <= 1'b0;
                        r_depth    <= w_depth_next;
                        r_index    <= w_index_next;
                        if (w_depth_err) begin
                            err_code <= TR_ERR_DEPTH;
                            busy     <= 1'b0;
                            r_state  <= S_ERROR;
                        end else if (w_index_next == r_len) begin
                            busy <= 1'b0;
                            if (w_depth_next != '0) begin
                                err_code <= TR_ERR_DEPTH;
                                r_state  <= S_ERROR;
                            end else begin
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= w_index_next;
                            r_state   <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_structure_tape_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_structure_tape_reader
// Description : Directed self-checking bench for structure_tape_reader with a
//               one-cycle-latency tape RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_structure_tape_reader;
    import structure_tape_reader_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    tape_index_t   tape_len = '0;
    logic          mem_rd_en;
    tape_index_t   mem_addr;
    logic [63:0]   mem_rd_data = '0;
    logic          elem_valid;
    logic          elem_ready = 1'b1;
    element_type_t elem_type;
    logic [55:0]   elem_payload;
    logic [63:0]   elem_value;
    tape_index_t   elem_index;
    logic [5:0]    elem_depth;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;

    logic [63:0]   mem [0:15];
    int            rd_cnt = 0;

    int            n_total = 0;
    int            n_bad   = 0;

    element_type_t got_type [8];
    logic [55:0]   got_pl   [8];
    logic [63:0]   got_val  [8];
    tape_index_t   got_idx  [8];
    logic [5:0]    got_dep  [8];
    int            n_got;
    int            n_reads;
    int            done_cyc;
    bit            got_done;

    structure_tape_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .tape_len     (tape_len),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .elem_valid   (elem_valid),
        .elem_ready   (elem_ready),
        .elem_type    (elem_type),
        .elem_payload (elem_payload),
        .elem_value   (elem_value),
        .elem_index   (elem_index),
        .elem_depth   (elem_depth),
        .busy         (busy),
        .done         (done),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    // Tape RAM: data appears one cycle after the read enable.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_addr[3:0]];
            rd_cnt      <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 64'h0;
    endtask

    // Pulse start, then collect accepted elements until done or error.
    task automatic walk(input int len);
        int rd0;
        bit ended;
        n_got    = 0;
        got_done = 0;
        done_cyc = -1;
        ended    = 0;
        @(negedge clk);
        tape_len = tape_index_t'(len);
        start    = 1'b1;
        rd0      = rd_cnt;
        @(negedge clk);
        start    = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (elem_valid && elem_ready && n_got < 8) begin
                got_type[n_got] = elem_type;
                got_pl[n_got]   = elem_payload;
                got_val[n_got]  = elem_value;
                got_idx[n_got]  = elem_index;
                got_dep[n_got]  = elem_depth;
                n_got++;
            end
            if (done) begin
                got_done = 1;
                done_cyc = i;
                ended    = 1;
                break;
            end
            if (!busy && err_code != 2'd0) begin
                ended = 1;
                break;
            end
            @(negedge clk);
        end
        n_reads = rd_cnt - rd0;
        check("walk_terminates", 64'(ended), 64'd1);
    endtask

    initial begin
        logic [55:0] snap_pl;
        tape_index_t snap_idx;
        int          snap_rd;
        bit          stable;
        bit          seen;

        clear_mem();
        // Reset state
        @(negedge clk);
        check("rst_outputs",
              {63'd0, mem_rd_en | elem_valid | busy | done},
              64'd0);
        check("rst_err", 64'(err_code), 64'd0);
        check("rst_fields", {elem_payload, 8'h00} | elem_value | 64'(elem_index)
              | 64'(elem_depth) | 64'(mem_addr) | 64'(elem_type), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single string element
        mem[0] = 64'h2200_0000_0000_0010;
        walk(1);
        check("str_count", 64'(n_got), 64'd1);
        check("str_type", 64'(got_type[0]), 64'(ELEM_STR));
        check("str_payload", 64'(got_pl[0]), 64'h10);
        check("str_index", 64'(got_idx[0]), 64'd0);
        check("str_depth", 64'(got_dep[0]), 64'd0);
        check("str_done", 64'(got_done), 64'd1);
        check("str_err", 64'(err_code), 64'd0);
        @(negedge clk);
        check("str_done_pulse", 64'(done), 64'd0);

        // Nested object/array, depth tracking
        clear_mem();
        mem[0] = 64'h7B00_0000_0000_0003;
        mem[1] = 64'h5B00_0000_0000_0002;
        mem[2] = 64'h5D00_0000_0000_0001;
        mem[3] = 64'h7D00_0000_0000_0000;
        walk(4);
        check("nest_count", 64'(n_got), 64'd4);
        check("nest_t0", 64'(got_type[0]), 64'(ELEM_OBJ_OPEN));
        check("nest_t1", 64'(got_type[1]), 64'(ELEM_ARRAY_OPEN));
        check("nest_t2", 64'(got_type[2]), 64'(ELEM_ARRAY_CLOSE));
        check("nest_t3", 64'(got_type[3]), 64'(ELEM_OBJ_CLOSE));
        check("nest_d0", 64'(got_dep[0]), 64'd0);
        check("nest_d1", 64'(got_dep[1]), 64'd1);
        check("nest_d2", 64'(got_dep[2]), 64'd2);
        check("nest_d3", 64'(got_dep[3]), 64'd1);
        check("nest_pl0", 64'(got_pl[0]), 64'd3);
        check("nest_done", 64'(got_done), 64'd1);
        check("nest_err", 64'(err_code), 64'd0);

        // Unsigned number with value word, followed by null
        clear_mem();
        mem[0] = 64'h7500_0000_0000_0000;
        mem[1] = 64'h0000_0000_DEAD_BEEF;
        mem[2] = 64'h6E00_0000_0000_0000;
        walk(3);
        check("num_count", 64'(n_got), 64'd2);
        check("num_type", 64'(got_type[0]), 64'(ELEM_UINT));
        check("num_value", got_val[0], 64'hDEAD_BEEF);
        check("num_index", 64'(got_idx[0]), 64'd0);
        check("null_type", 64'(got_type[1]), 64'(ELEM_NULL));
        check("null_index", 64'(got_idx[1]), 64'd2);
        check("null_value", got_val[1], 64'd0);
        check("num_done", 64'(got_done), 64'd1);
        check("num_reads", 64'(n_reads), 64'd3);

        // Double with no value word
        clear_mem();
        mem[0] = 64'h6400_0000_0000_0000;
        walk(1);
        check("trunc_err", 64'(err_code), 64'd3);
        check("trunc_no_elem", 64'(n_got), 64'd0);
        check("trunc_no_done", 64'(got_done), 64'd0);
        check("trunc_busy", 64'(busy), 64'd0);

        // Bad prefix, then recovery
        mem[0] = 64'h4100_0000_0000_0000;
        walk(1);
        check("badpfx_err", 64'(err_code), 64'd1);
        check("badpfx_no_elem", 64'(n_got), 64'd0);
        repeat (3) @(negedge clk);
        check("badpfx_sticky", 64'(err_code), 64'd1);
        mem[0] = 64'h2200_0000_0000_0010;
        walk(1);
        check("recover_err", 64'(err_code), 64'd0);
        check("recover_done", 64'(got_done), 64'd1);
        check("recover_count", 64'(n_got), 64'd1);

        // Backpressure: element holds still and no further reads are issued
        clear_mem();
        mem[0] = 64'h2200_0000_0000_0055;
        mem[1] = 64'h7400_0000_0000_0000;
        elem_ready = 1'b0;
        @(negedge clk);
        tape_len = tape_index_t'(2);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        seen     = 0;
        for (int i = 0; i < 20; i++) begin
            if (elem_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("bp_valid", 64'(seen), 64'd1);
        snap_pl  = elem_payload;
        snap_idx = elem_index;
        snap_rd  = rd_cnt;
        stable   = 1;
        repeat (10) begin
            @(negedge clk);
            if (!elem_valid || elem_payload != snap_pl || elem_index != snap_idx
                || elem_type != ELEM_STR || mem_rd_en)
                stable = 0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_payload", 64'(snap_pl), 64'h55);
        check("bp_no_reads", 64'(rd_cnt - snap_rd), 64'd0);
        elem_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (elem_valid && elem_type == ELEM_TRUE && elem_index == tape_index_t'(1))
                seen = 1;
            if (done) break;
        end
        check("bp_second_elem", 64'(seen), 64'd1);
        check("bp_done", 64'(done), 64'd1);

        // Reset while waiting for a number value word
        clear_mem();
        mem[0] = 64'h6C00_0000_0000_0000;
        mem[1] = 64'h0000_0000_0000_0005;
        @(negedge clk);
        tape_len = tape_index_t'(2);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs",
              64'({mem_rd_en, elem_valid, busy, done, err_code}), 64'd0);
        check("mid_rst_fields", elem_value | 64'(elem_index) | 64'(mem_addr)
              | 64'(elem_payload) | 64'(elem_type) | 64'(elem_depth), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mem[0] = 64'h2200_0000_0000_0010;
        walk(1);
        check("post_rst_done", 64'(got_done), 64'd1);
        check("post_rst_payload", 64'(got_pl[0]), 64'h10);

        // Close with nothing open: delivered, then depth error
        mem[0] = 64'h7D00_0000_0000_0000;
        walk(1);
        check("uflow_count", 64'(n_got), 64'd1);
        check("uflow_type", 64'(got_type[0]), 64'(ELEM_OBJ_CLOSE));
        check("uflow_err", 64'(err_code), 64'd2);
        check("uflow_no_done", 64'(got_done), 64'd0);

        // Unclosed open at end of tape
        mem[0] = 64'h5B00_0000_0000_0000;
        walk(1);
        check("unclosed_err", 64'(err_code), 64'd2);
        check("unclosed_count", 64'(n_got), 64'd1);

        // Empty tape: immediate done, no reads
        walk(0);
        check("empty_done", 64'(got_done), 64'd1);
        check("empty_done_cyc", 64'(done_cyc), 64'd0);
        check("empty_reads", 64'(n_reads), 64'd0);
        check("empty_err", 64'(err_code), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
